fsx_timing_mixer: RTL

- Parametrised successor to the GPU frame synthesizer top, placed between the renderers and the LCD/VGA pins.
- Generates the video timing and the pixel coordinates used by the renderers.
- Composites NUM_LAYERS renderer outputs by priority and a per-pixel valid flag, with sync and blank delayed to match renderer pipeline latency.
- Raises frame-done and programmable line-compare interrupt pulses.

---
 rtl/fsx_timing_mixer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fsx_timing_mixer.sv
// Video timing generator with priority layer compositor, renderer-latency-matched
// sync/blank pins, and frame-done / line-compare interrupt pulses.
module fsx_timing_mixer #(
  parameter int unsigned H_RES      = 480,
  parameter int unsigned V_RES      = 272,
  parameter int unsigned H_FP       = 82,
  parameter int unsigned H_SYNC     = 41,
  parameter int unsigned H_BP       = 2,
  parameter int unsigned V_FP       = 2,
  parameter int unsigned V_SYNC     = 10,
  parameter int unsigned V_BP       = 2,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned PIPE       = 2
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  output logic [9:0]              h_count,
  output logic [8:0]              v_count,
  output logic [9:0]              o_h,
  output logic [8:0]              o_v,
  output logic                    o_de,
  output logic                    o_frame,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_valid,
  input  logic                    line_irq_en,
  input  logic [8:0]              line_irq_line,
  output logic [2:0]              vga_r,
  output logic [2:0]              vga_g,
  output logic [1:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_de,
  output logic                    frameDrawn,
  output logic                    line_irq
);

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 9;
  localparam int unsigned PW = 8;
  localparam int unsigned TW = 3;

  localparam int unsigned HS_STA = H_FP - 1;
  localparam int unsigned HS_END = HS_STA + H_SYNC;
  localparam int unsigned HA_STA = HS_END + H_BP;
  localparam int unsigned LINE   = HA_STA + H_RES;
  localparam int unsigned VS_STA = V_FP - 1;
  localparam int unsigned VS_END = VS_STA + V_SYNC;
  localparam int unsigned VA_STA = VS_END + V_BP;
  localparam int unsigned FRAME  = VA_STA + V_RES;

  localparam logic [HW-1:0] HS_STA_C   = HW'(HS_STA);
  localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);
  localparam logic [HW-1:0] HA_STA_C   = HW'(HA_STA);
  localparam logic [HW-1:0] LINE_C     = HW'(LINE);
  localparam logic [HW-1:0] HA_FIRST_C = HW'(HA_STA + 1);
  localparam logic [VW-1:0] VS_STA_C   = VW'(VS_STA);
  localparam logic [VW-1:0] VS_END_C   = VW'(VS_END);
  localparam logic [VW-1:0] VA_STA_C   = VW'(VA_STA);
  localparam logic [VW-1:0] FRAME_C    = VW'(FRAME);
  localparam logic [VW-1:0] VA_FIRST_C = VW'(VA_STA + 1);
  localparam logic [VW-1:0] V_RES_C    = VW'(V_RES);

  logic          h_end;
  logic          v_end;
  logic          hs_raw;
  logic          vs_raw;
  logic          h_act;
  logic          v_act;
  logic [VW-1:0] v_line;
  logic          line_hit;
  logic          shadow_en;
  logic [VW-1:0] shadow_line;
  logic [PW-1:0] mix;
  logic [TW-1:0] tap_raw;
  logic [TW-1:0] tap_dly;
  logic          unused_valid0;

  // Layer 0 is the background and is always opaque.
  assign unused_valid0 = layer_valid[0];

  assign h_end = (h_count == LINE_C);
  assign v_end = (v_count == FRAME_C);

  // Raster position counters: h every clock, v on each line wrap.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_end) begin
      h_count <= '0;
      v_count <= v_end ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Coordinate-time decode of sync, active window and renderer coordinates.
  always_comb begin
    hs_raw  = (h_count > HS_STA_C) && (h_count <= HS_END_C);
    vs_raw  = (v_count > VS_STA_C) && (v_count <= VS_END_C);
    h_act   = (h_count > HA_STA_C) && (h_count <= LINE_C);
    v_act   = (v_count > VA_STA_C) && (v_count <= FRAME_C);
    o_de    = h_act && v_act;
    o_h     = o_de ? (h_count - HA_FIRST_C) : '0;
    o_v     = o_de ? (v_count - VA_FIRST_C) : '0;
    o_frame = (h_count == '0) && (v_count == '0);
  end

  assign tap_raw = {hs_raw, vs_raw, o_de};

  generate
    if (PIPE == 0) begin : g_no_delay
      assign tap_dly = tap_raw;
    end else begin : g_delay
      logic [TW-1:0] dly_q [PIPE];

      // Delay sync/blank by the renderer latency; reset flushes to inactive.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < PIPE; i++) begin
            dly_q[i] <= '0;
          end
        end else begin
          dly_q[0] <= tap_raw;
          for (int unsigned i = 1; i < PIPE; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign tap_dly = dly_q[PIPE-1];
    end
  endgenerate

  // Priority compositor: highest-index valid layer above the background wins.
  always_comb begin
    mix = layer_rgb[PW-1:0];
    for (int unsigned k = 1; k < NUM_LAYERS; k++) begin
      if (layer_valid[k]) begin
        mix = layer_rgb[k*PW +: PW];
      end
    end
  end

  // Pin-side output register: blanked pixel, sync at programmed polarity.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs                <= ~H_POL;
      vga_vs                <= ~V_POL;
      vga_de                <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= tap_dly[0] ? mix : '0;
      vga_hs                <= ~(tap_dly[2] ^ H_POL);
      vga_vs                <= ~(tap_dly[1] ^ V_POL);
      vga_de                <= tap_dly[0];
    end
  end

  // Frame-atomic capture of the line-compare settings at frame start.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shadow_en   <= 1'b0;
      shadow_line <= '0;
    end else if (o_frame) begin
      shadow_en   <= line_irq_en;
      shadow_line <= line_irq_line;
    end
  end

  assign v_line   = v_count - VA_FIRST_C;
  assign line_hit = shadow_en && h_end && v_act &&
                    (shadow_line < V_RES_C) && (v_line == shadow_line);

  // Interrupt pulses, one clock after the end of the matching line.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frameDrawn <= 1'b0;
      line_irq   <= 1'b0;
    end else begin
      frameDrawn <= h_end && v_end;
      line_irq   <= line_hit;
    end
  end

endmodule
